glitch_trigger_sequencer: RTL

Parametrised multi-channel delayed-trigger generator for the glitchy-clock injection path. On an accepted rising edge of the target's trigger, each enabled channel waits a fine delay in clock cycles plus a coarse delay in whole blocks of `BLK_LEN` cycles, then emits a pulse of programmable width. The block sits between the target's trigger and the glitch-clock select logic, one channel per glitch source. Compared with the single-channel delay chain, it adds channel count, a programmable pulse width, an arm/auto-rearm control and a busy/done status.

---
 rtl/glitch_trigger_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/glitch_trigger_sequencer.sv
// glitch_trigger_sequencer
//
// Multi-channel delayed-trigger generator for the glitch-clock injection
// path. A rising edge on trig_in is accepted when the block is armed and
// every channel is idle. Each enabled channel then latches its delay and
// width settings. It waits F fine cycles plus C coarse blocks of BLK_LEN
// cycles, and then drives trig_out for max(W,1) cycles.
//
// Ports
//   clk         single clock, rising edge
//   rst_in      asynchronous active-high reset
//   trig_in     target trigger, already synchronous to clk
//   arm         one-cycle pulse, sets the armed flag
//   auto_rearm  1: keep armed set after an accepted edge
//   ch_en       per-channel enable, sampled on the accepted edge
//   fine_dly    per-channel fine delay F, channel i at [i*CNT_W +: CNT_W]
//   coarse_dly  per-channel coarse block count C, same packing
//   pulse_w     per-channel pulse width W, channel i at [i*PW_W +: PW_W]
//   armed       armed flag
//   trig_out    delayed trigger pulses
//   busy        channel is in FINE, COARSE or PULSE
//   done        one-cycle pulse on the last high cycle of trig_out
module glitch_trigger_sequencer #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 16,
  parameter int PW_W    = 8,
  parameter int BLK_LEN = 577
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    trig_in,
  input  logic                    arm,
  input  logic                    auto_rearm,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [N_CH*CNT_W-1:0]   fine_dly,
  input  logic [N_CH*CNT_W-1:0]   coarse_dly,
  input  logic [N_CH*PW_W-1:0]    pulse_w,
  output logic                    armed,
  output logic [N_CH-1:0]         trig_out,
  output logic [N_CH-1:0]         busy,
  output logic [N_CH-1:0]         done
);

  localparam int BLK_W = $clog2(BLK_LEN + 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLK_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FINE,
    S_COARSE,
    S_PULSE
  } state_t;

  logic trig_prev_reg;
  logic armed_reg;
  logic accept;

  // A new sequence may only start when every channel has finished. Edges
  // seen while any channel is busy are dropped and do not restart anything.
  assign accept = trig_in & ~trig_prev_reg & armed_reg & ~(|busy);
  assign armed  = armed_reg;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      trig_prev_reg <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      trig_prev_reg <= trig_in;
      // arm wins over the clear caused by a same-cycle accepted edge.
      armed_reg     <= arm | (armed_reg & ~(accept & ~auto_rearm));
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   fine_cnt_reg, fine_cnt_next;
    logic [CNT_W-1:0]   blk_idx_reg, blk_idx_next;
    logic [BLK_W-1:0]   blk_cnt_reg, blk_cnt_next;
    logic [PW_W-1:0]    pw_cnt_reg, pw_cnt_next;
    logic [CNT_W-1:0]   f_reg, f_next;
    logic [CNT_W-1:0]   c_reg, c_next;
    logic [PW_W-1:0]    w_reg, w_next;
    logic [PW_W-1:0]    w_eff_reg, w_eff_next;
    logic [CNT_W-1:0]   f_in, c_in;
    logic [PW_W-1:0]    w_in;
    logic               trig_reg, busy_reg, done_reg;

    assign f_in = fine_dly[gi*CNT_W +: CNT_W];
    assign c_in = coarse_dly[gi*CNT_W +: CNT_W];
    assign w_in = pulse_w[gi*PW_W +: PW_W];

    // A zero width still produces a single-cycle pulse.
    assign w_eff_reg  = (w_reg == '0) ? PW_W'(1) : w_reg;
    assign w_eff_next = (w_next == '0) ? PW_W'(1) : w_next;

    // Every counter runs from 1 up to its latched limit and is compared
    // for equality. An all-ones limit therefore never wraps, and the
    // coarse delay is C nested blocks, so no multiplier is needed.
    always_comb begin
      state_next    = state_reg;
      fine_cnt_next = fine_cnt_reg;
      blk_idx_next  = blk_idx_reg;
      blk_cnt_next  = blk_cnt_reg;
      pw_cnt_next   = pw_cnt_reg;
      f_next        = f_reg;
      c_next        = c_reg;
      w_next        = w_reg;
      case (state_reg)
        S_IDLE: begin
          if (accept && ch_en[gi]) begin
            f_next = f_in;
            c_next = c_in;
            w_next = w_in;
            if (f_in != '0) begin
              state_next    = S_FINE;
              fine_cnt_next = CNT_W'(1);
            end else if (c_in != '0) begin
              state_next   = S_COARSE;
              blk_cnt_next = BLK_W'(1);
              blk_idx_next = CNT_W'(1);
            end else begin
              state_next  = S_PULSE;
              pw_cnt_next = PW_W'(1);
            end
          end
        end
        S_FINE: begin
          if (fine_cnt_reg == f_reg) begin
            fine_cnt_next = '0;
            if (c_reg != '0) begin
              state_next   = S_COARSE;
              blk_cnt_next = BLK_W'(1);
              blk_idx_next = CNT_W'(1);
            end else begin
              state_next  = S_PULSE;
              pw_cnt_next = PW_W'(1);
            end
          end else begin
            fine_cnt_next = fine_cnt_reg + CNT_W'(1);
          end
        end
        S_COARSE: begin
          if (blk_cnt_reg == BLK_LAST) begin
            if (blk_idx_reg == c_reg) begin
              blk_cnt_next = '0;
              blk_idx_next = '0;
              state_next   = S_PULSE;
              pw_cnt_next  = PW_W'(1);
            end else begin
              blk_cnt_next = BLK_W'(1);
              blk_idx_next = blk_idx_reg + CNT_W'(1);
            end
          end else begin
            blk_cnt_next = blk_cnt_reg + BLK_W'(1);
          end
        end
        S_PULSE: begin
          if (pw_cnt_reg >= w_eff_reg) begin
            state_next  = S_IDLE;
            pw_cnt_next = '0;
          end else begin
            pw_cnt_next = pw_cnt_reg + PW_W'(1);
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end

    // The outputs are registered from the next-state values. They change
    // only on a clock edge and never glitch on the way to the clock-select
    // logic.
    always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
        state_reg    <= S_IDLE;
        fine_cnt_reg <= '0;
        blk_idx_reg  <= '0;
        blk_cnt_reg  <= '0;
        pw_cnt_reg   <= '0;
        f_reg        <= '0;
        c_reg        <= '0;
        w_reg        <= '0;
        trig_reg     <= 1'b0;
        busy_reg     <= 1'b0;
        done_reg     <= 1'b0;
      end else begin
        state_reg    <= state_next;
        fine_cnt_reg <= fine_cnt_next;
        blk_idx_reg  <= blk_idx_next;
        blk_cnt_reg  <= blk_cnt_next;
        pw_cnt_reg   <= pw_cnt_next;
        f_reg        <= f_next;
        c_reg        <= c_next;
        w_reg        <= w_next;
        trig_reg     <= (state_next == S_PULSE);
        busy_reg     <= (state_next != S_IDLE);
        done_reg     <= (state_next == S_PULSE) && (pw_cnt_next == w_eff_next);
      end
    end

    assign trig_out[gi] = trig_reg;
    assign busy[gi]     = busy_reg;
    assign done[gi]     = done_reg;
  end

endmodule
